hex_scan_ctrl: RTL and testbench
================================

HEX_SCAN_CTRL -- requirements
Module: hex_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning clock cycles between single-position refreshes in scan mode (legal range 2..2^20).
REQ-002 SHALL have port CLOCK_50  input  1  system clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port RESET_N  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port load_valid  input  1  requester presents a new 4-digit value.
REQ-005 SHALL have port load_digits  input  16  four 4-bit digit codes; nibble k ([4k+3:4k]) is shown on HEXk.
REQ-006 SHALL have port load_ready  output  1  controller can accept a load this cycle.
REQ-007 SHALL have port blank_n  input  1  low forces all four displays dark, without losing stored digits.
REQ-008 SHALL have ports HEX0, HEX1, HEX2, HEX3  output  7 each  segment drives, active-low, bit0=a .. bit6=g, registered.
REQ-009 SHALL have port frame_done  output  1  one-cycle pulse after HEX3 is written, completing a full 4-position refresh.

Function
REQ-010 SHALL own exactly one digit-to-segment decoder, time-shared across all four positions through a position index idx (2 bits).
REQ-011 The decoder SHALL map codes 0..9 to 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001, 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0010000 (bit6..bit0). It SHALL map codes 10..15 to 1111111 (blank).
REQ-012 SHALL implement FSM states IDLE, UPDATE, SCAN.
REQ-013 In IDLE, outputs SHALL stay blank and load_ready SHALL be 1; an accepted load SHALL go to UPDATE with idx=0.
REQ-014 A load SHALL be accepted on an edge where load_valid=1 and load_ready=1; load_digits SHALL be captured into the digit register on that same edge.
REQ-015 In UPDATE, load_ready SHALL be 0, and the controller SHALL write HEX0, HEX1, HEX2 and HEX3 on the 4 consecutive edges after acceptance (edges N+1..N+4).
REQ-016 After the UPDATE write to HEX3, frame_done SHALL be 1 for exactly one cycle and the state SHALL go to SCAN, with the divider cleared and idx=0.
REQ-017 In SCAN, the divider SHALL count 0..SCAN_DIV-1; at terminal count, the controller SHALL rewrite HEX[idx] from the stored digit and then idx SHALL advance, wrapping 3 -> 0.
REQ-018 In SCAN, the rewrite of HEX3 SHALL pulse frame_done for one cycle.
REQ-019 In SCAN, load_ready SHALL be 1.
REQ-020 If a load and a divider terminal count occur on the same edge, the load SHALL win: the tick refresh is dropped and the controller enters UPDATE exactly as in REQ-015.
REQ-021 While blank_n=0, every HEX write SHALL write 1111111 instead of the decoded value. Stored digits, idx, divider and FSM SHALL be unaffected. After blank_n returns high, each position SHALL recover on its next refresh.
REQ-022 load_ready SHALL be a registered function of state only, with no combinational path from load_valid.

Reset
REQ-023 On an edge with RESET_N=0, the following SHALL take effect: HEX0..HEX3=1111111, digit register=0, idx=0, divider=0, state=IDLE, frame_done=0, load_ready=1.
REQ-024 Reset asserted mid-UPDATE or mid-SCAN SHALL abort the operation on that edge. Any load presented during reset SHALL be ignored.

Structure
REQ-025 A shared package SHALL hold the FSM state encoding, the blank constant 7'b1111111, and the segment table constants.
REQ-026 The decoder SHALL be a separate sub-module, seg_decode (4-bit in, 7-bit out, purely combinational), instantiated once.
REQ-027 The divider width SHALL be derived from SCAN_DIV by clog2.

Verification
REQ-028 Reset, then no load for 100 cycles -> all HEX = 1111111, load_ready=1, frame_done never pulses.
REQ-029 SCAN_DIV=4; load 16'h1814 at edge N -> the following SHALL be observed:
- HEX0=0011001 at N+1.
- HEX1=1111001 at N+2.
- HEX2=0000000 at N+3.
- HEX3=1111001 at N+4.
- frame_done high only in cycle N+4..N+5.
- load_ready low during N+1..N+4.
REQ-030 SCAN_DIV=4, digits 16'h0000, in SCAN -> each position is rewritten with 1000000 every 4 cycles in order 0,1,2,3. frame_done pulses every 16 cycles.
REQ-031 Load 16'h9A5F -> HEX3=0010000, HEX2=1111111, HEX1=0010010, HEX0=1111111.
REQ-032 Load asserted on the same edge as the divider terminal count -> UPDATE sequence starts with HEX0 at the next edge. The dropped tick position is not rewritten.
REQ-033 Covers blank and reset in one run:
- Pull blank_n low for 20 cycles in SCAN -> positions go dark as they are refreshed, then restore after blank_n returns high.
- Assert RESET_N=0 at UPDATE edge N+2 -> all HEX blank and state IDLE on that edge.

Source files
------------

// File: rtl/hex_scan_ctrl_pkg.sv
// Shared definitions for the four-digit seven-segment scan controller:
// FSM encoding, the dark-segment pattern and the digit segment table.
package hex_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        SCAN   = 2'd2
    } state_t;

    // Segment patterns are active-low, bit6 = g .. bit0 = a
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

endpackage

// File: rtl/seg_decode.sv
// Combinational digit-to-segment decoder; codes above 9 show nothing.
module seg_decode
    import hex_scan_ctrl_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);

    // Table lookup of the active-low segment pattern for one digit code
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_code)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_scan_ctrl.sv
// Four-position seven-segment controller. A load writes all four displays
// on consecutive cycles, then the controller keeps refreshing one position
// every SCAN_DIV cycles through a single shared decoder.
module hex_scan_ctrl
    import hex_scan_ctrl_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic        load_valid,
    input  logic [15:0] load_digits,
    output logic        load_ready,
    input  logic        blank_n,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic        frame_done
);

    localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    state_t           r_state;
    logic [15:0]      r_digits;
    logic [1:0]       r_idx;
    logic [DIV_W-1:0] r_div;
    logic [6:0]       r_hex0;
    logic [6:0]       r_hex1;
    logic [6:0]       r_hex2;
    logic [6:0]       r_hex3;
    logic             r_frame_done;
    logic             r_load_ready;

    logic [3:0]       w_code;
    logic [6:0]       w_seg;
    logic [6:0]       w_wr_val;
    logic             w_accept;
    logic             w_tick;
    logic             w_wr_en;

    // The single decoder always looks at the digit of the current position
    assign w_code   = r_digits[{r_idx, 2'b00} +: 4];

    seg_decode u_seg_decode (
        .i_code (w_code),
        .o_seg  (w_seg)
    );

    assign w_wr_val = blank_n ? w_seg : SEG_BLANK;
    assign w_accept = load_valid & r_load_ready;
    assign w_tick   = (r_div == DIV_LAST);

    // A position is written every UPDATE cycle, and in SCAN on a divider
    // tick unless a load arrives on the same edge (the load wins)
    always_comb begin
        w_wr_en = 1'b0;
        if (r_state == UPDATE) begin
            w_wr_en = 1'b1;
        end else if (r_state == SCAN) begin
            w_wr_en = w_tick & ~w_accept;
        end
    end

    // Controller FSM: load capture, UPDATE burst, periodic SCAN refresh
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            r_state      <= IDLE;
            r_digits     <= 16'h0000;
            r_idx        <= 2'd0;
            r_div        <= '0;
            r_hex0       <= SEG_BLANK;
            r_hex1       <= SEG_BLANK;
            r_hex2       <= SEG_BLANK;
            r_hex3       <= SEG_BLANK;
            r_frame_done <= 1'b0;
            r_load_ready <= 1'b1;
        end else begin
            r_frame_done <= 1'b0;

            if (w_wr_en) begin
                case (r_idx)
                    2'd0:    r_hex0 <= w_wr_val;
                    2'd1:    r_hex1 <= w_wr_val;
                    2'd2:    r_hex2 <= w_wr_val;
                    default: r_hex3 <= w_wr_val;
                endcase
            end

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state      <= UPDATE;
                        r_idx        <= 2'd0;
                        r_digits     <= load_digits;
                        r_load_ready <= 1'b0;
                    end
                end
                UPDATE: begin
                    r_idx <= r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        r_state      <= SCAN;
                        r_div        <= '0;
                        r_frame_done <= 1'b1;
                        r_load_ready <= 1'b1;
                    end
                end
                SCAN: begin
                    if (w_accept) begin
                        r_state      <= UPDATE;
                        r_idx        <= 2'd0;
                        r_digits     <= load_digits;
                        r_load_ready <= 1'b0;
                    end else if (w_tick) begin
                        r_div <= '0;
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_frame_done <= 1'b1;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_load_ready <= 1'b1;
                end
            endcase
        end
    end

    assign HEX0       = r_hex0;
    assign HEX1       = r_hex1;
    assign HEX2       = r_hex2;
    assign HEX3       = r_hex3;
    assign frame_done = r_frame_done;
    assign load_ready = r_load_ready;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Bench for hex_scan_ctrl with SCAN_DIV=4. Expected observations are queued
// with the cycle they are due in; a monitor pops and compares them.
module tb_hex_scan_ctrl;

    localparam int         SCAN_DIV = 4;
    localparam logic [6:0] BLK      = 7'b1111111;

    logic        CLOCK_50 = 1'b0;
    logic        RESET_N;
    logic        load_valid;
    logic [15:0] load_digits;
    logic        load_ready;
    logic        blank_n;
    logic [6:0]  HEX0;
    logic [6:0]  HEX1;
    logic [6:0]  HEX2;
    logic [6:0]  HEX3;
    logic        frame_done;

    hex_scan_ctrl #(.SCAN_DIV(SCAN_DIV)) dut (
        .CLOCK_50    (CLOCK_50),
        .RESET_N     (RESET_N),
        .load_valid  (load_valid),
        .load_digits (load_digits),
        .load_ready  (load_ready),
        .blank_n     (blank_n),
        .HEX0        (HEX0),
        .HEX1        (HEX1),
        .HEX2        (HEX2),
        .HEX3        (HEX3),
        .frame_done  (frame_done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Edge counter: at the falling edge after rising edge k, cyc == k
    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    int fd_cnt   = 0;

    typedef struct {
        int         cyc;
        string      tag;
        int         sel;   // 0..3 HEXn, 4 frame_done, 5 load_ready
        logic [6:0] val;
    } exp_t;

    exp_t sb[$];

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h (t=%0t cyc=%0d)", tag, got, exp, $time, cyc);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] c);
        case (c)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [15:0] pick(input int sel);
        case (sel)
            0:       return {9'd0, HEX0};
            1:       return {9'd0, HEX1};
            2:       return {9'd0, HEX2};
            3:       return {9'd0, HEX3};
            4:       return {15'd0, frame_done};
            default: return {15'd0, load_ready};
        endcase
    endfunction

    task automatic push(input int c, input string tag, input int sel, input logic [6:0] v);
        exp_t e;
        e.cyc = c;
        e.tag = tag;
        e.sel = sel;
        e.val = v;
        sb.push_back(e);
    endtask

    // Full UPDATE burst following acceptance at edge n
    task automatic expect_update(input int n, input logic [15:0] d, input bit blk);
        for (int k = 0; k < 4; k++) begin
            push(n + 1 + k, $sformatf("upd%0d_hex%0d", n, k), k, blk ? BLK : seg_of(d[4*k +: 4]));
            push(n + k, $sformatf("upd%0d_rdy_lo%0d", n, k), 5, 7'd0);
        end
        push(n + 4, $sformatf("upd%0d_rdy_back", n), 5, 7'd1);
        push(n + 3, $sformatf("upd%0d_fd_pre", n), 4, 7'd0);
        push(n + 4, $sformatf("upd%0d_fd", n), 4, 7'd1);
        push(n + 5, $sformatf("upd%0d_fd_post", n), 4, 7'd0);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge CLOCK_50);
    endtask

    // Present a load for the next edge; returns that edge number
    task automatic do_load(input logic [15:0] d, input bit exp_upd, input bit blk, output int n);
        n           = cyc + 1;
        load_valid  = 1'b1;
        load_digits = d;
        if (exp_upd) expect_update(n, d, blk);
        @(negedge CLOCK_50);
        load_valid  = 1'b0;
    endtask

    // Scoreboard monitor, sampling on the falling edge
    always @(negedge CLOCK_50) begin
        if (frame_done) fd_cnt++;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                check_eq(sb[i].tag, pick(sb[i].sel), {9'd0, sb[i].val});
                sb.delete(i);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc %0d exp finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, e, e2, e3, n4, e4, m;

        RESET_N     = 1'b0;
        load_valid  = 1'b1;          // load during reset must be ignored
        load_digits = 16'h1234;
        blank_n     = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        RESET_N     = 1'b0;
        check_eq("rst_hex0", {9'd0, HEX0}, {9'd0, BLK});
        check_eq("rst_hex1", {9'd0, HEX1}, {9'd0, BLK});
        check_eq("rst_hex2", {9'd0, HEX2}, {9'd0, BLK});
        check_eq("rst_hex3", {9'd0, HEX3}, {9'd0, BLK});
        check_eq("rst_rdy",  {15'd0, load_ready}, 16'd1);
        check_eq("rst_fd",   {15'd0, frame_done}, 16'd0);
        RESET_N     = 1'b1;
        load_valid  = 1'b0;
        fd_cnt      = 0;

        // Idle with no load for 100 cycles
        repeat (100) @(negedge CLOCK_50);
        check_eq("idle_hex0", {9'd0, HEX0}, {9'd0, BLK});
        check_eq("idle_hex1", {9'd0, HEX1}, {9'd0, BLK});
        check_eq("idle_hex2", {9'd0, HEX2}, {9'd0, BLK});
        check_eq("idle_hex3", {9'd0, HEX3}, {9'd0, BLK});
        check_eq("idle_rdy",  {15'd0, load_ready}, 16'd1);
        check_eq("idle_fd_cnt", 16'(fd_cnt), 16'd0);

        // Load 1814 from IDLE, then first scan frame
        do_load(16'h1814, 1'b1, 1'b0, n);
        e = n + 4;
        push(e + 1,  "scan1_rdy",     5, 7'd1);
        push(e + 4,  "scan1_hex0",    0, seg_of(4'd4));
        push(e + 15, "scan1_fd_pre",  4, 7'd0);
        push(e + 16, "scan1_fd",      4, 7'd1);
        push(e + 17, "scan1_fd_post", 4, 7'd0);

        // Load 0000 with blanking over the UPDATE, so scan refreshes are visible
        wait_cyc(e + 17);
        blank_n = 1'b0;
        do_load(16'h0000, 1'b1, 1'b1, n);
        e2 = n + 4;
        wait_cyc(e2);
        blank_n = 1'b1;
        push(e2 + 3,  "scan0_hex0_dark",  0, BLK);
        push(e2 + 4,  "scan0_hex0",       0, seg_of(4'd0));
        push(e2 + 4,  "scan0_hex1_dark",  1, BLK);
        push(e2 + 8,  "scan0_hex1",       1, seg_of(4'd0));
        push(e2 + 8,  "scan0_hex2_dark",  2, BLK);
        push(e2 + 12, "scan0_hex2",       2, seg_of(4'd0));
        push(e2 + 12, "scan0_hex3_dark",  3, BLK);
        push(e2 + 16, "scan0_hex3",       3, seg_of(4'd0));
        push(e2 + 15, "scan0_fd_pre",     4, 7'd0);
        push(e2 + 16, "scan0_fd",         4, 7'd1);
        push(e2 + 31, "scan0_fd2_pre",    4, 7'd0);
        push(e2 + 32, "scan0_fd2",        4, 7'd1);

        // blank_n low for 20 edges while scanning
        wait_cyc(e2 + 32);
        blank_n = 1'b0;
        push(e2 + 36, "blk_hex0_dark",   0, BLK);
        push(e2 + 37, "blk_hex1_kept",   1, seg_of(4'd0));
        push(e2 + 40, "blk_hex1_dark",   1, BLK);
        push(e2 + 48, "blk_hex3_dark",   3, BLK);
        push(e2 + 48, "blk_fd",          4, 7'd1);
        push(e2 + 52, "blk_hex0_dark2",  0, BLK);
        wait_cyc(e2 + 52);
        blank_n = 1'b1;
        push(e2 + 55, "rec_hex0_still",  0, BLK);
        push(e2 + 56, "rec_hex1",        1, seg_of(4'd0));
        push(e2 + 60, "rec_hex2",        2, seg_of(4'd0));
        push(e2 + 64, "rec_hex3",        3, seg_of(4'd0));
        push(e2 + 68, "rec_hex0",        0, seg_of(4'd0));

        // Load 9A5F on a non-tick edge: codes above 9 show dark
        wait_cyc(e2 + 69);
        do_load(16'h9A5F, 1'b1, 1'b0, n);
        e3 = n + 4;

        // Load on the same edge as a tick refreshing HEX1 with blank_n low:
        // the dropped tick must leave HEX1 untouched
        wait_cyc(e3 + 7);
        blank_n = 1'b0;
        push(e3 + 8, "coin_hex1_kept",  1, seg_of(4'd5));
        push(e3 + 9, "coin_hex1_kept2", 1, seg_of(4'd5));
        do_load(16'h3210, 1'b1, 1'b0, n4);
        blank_n = 1'b1;
        e4 = n4 + 4;

        // Reset asserted at UPDATE edge m+2
        wait_cyc(e4 + 1);
        m = cyc + 1;
        push(m,     "abort_rdy_lo0", 5, 7'd0);
        push(m + 1, "abort_rdy_lo1", 5, 7'd0);
        push(m + 1, "abort_hex0",    0, seg_of(4'd4));
        do_load(16'h7654, 1'b0, 1'b0, n);
        @(negedge CLOCK_50);
        RESET_N     = 1'b0;
        load_valid  = 1'b1;
        load_digits = 16'h1111;
        push(m + 2, "abort_hex0_rst", 0, BLK);
        push(m + 2, "abort_hex1_rst", 1, BLK);
        push(m + 2, "abort_hex2_rst", 2, BLK);
        push(m + 2, "abort_hex3_rst", 3, BLK);
        push(m + 2, "abort_rdy_rst",  5, 7'd1);
        push(m + 2, "abort_fd_rst",   4, 7'd0);
        @(negedge CLOCK_50);
        RESET_N    = 1'b1;
        load_valid = 1'b0;
        push(m + 4, "abort_fd_none",  4, 7'd0);
        push(m + 6, "abort_idle_hex0", 0, BLK);
        push(m + 6, "abort_idle_hex3", 3, BLK);
        push(m + 6, "abort_idle_rdy", 5, 7'd1);
        wait_cyc(m + 8);

        check_eq("sb_drain", 16'(sb.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
